// File: rtl/gpio_bank_pkg.sv
// Shared GPIO bank definitions: register offsets, port stride, warm-up length.
// Pure declarations; no timing of its own.
// Not applicable: no flow control lives here.
package gpio_bank_pkg;

  // Byte offsets inside one port window (only bits [4:0] matter).
  localparam logic [4:0] GPIO_OFF_CR   = 5'h00;
  localparam logic [4:0] GPIO_OFF_OR   = 5'h04;
  localparam logic [4:0] GPIO_OFF_IR   = 5'h08;
  localparam logic [4:0] GPIO_OFF_IER  = 5'h0C;
  localparam logic [4:0] GPIO_OFF_ISR  = 5'h10;
  localparam logic [4:0] GPIO_OFF_EDGE = 5'h14;

  // Each port owns a 0x20-byte window; port index sits above it.
  localparam int GPIO_PORT_STRIDE = 32'h20;
  localparam int GPIO_PORT_SHIFT  = $clog2(GPIO_PORT_STRIDE);

  // Cycles after reset during which edge events are suppressed.
  localparam int GPIO_WARMUP = 2;

  typedef enum logic [2:0] {
    REG_CR,
    REG_OR,
    REG_IR,
    REG_IER,
    REG_ISR,
    REG_EDGE,
    REG_NONE
  } gpio_reg_e;

  // Map an in-window byte offset to the register it selects.
  function automatic gpio_reg_e gpio_decode(input logic [4:0] off);
    case (off)
      GPIO_OFF_CR:   return REG_CR;
      GPIO_OFF_OR:   return REG_OR;
      GPIO_OFF_IR:   return REG_IR;
      GPIO_OFF_IER:  return REG_IER;
      GPIO_OFF_ISR:  return REG_ISR;
      GPIO_OFF_EDGE: return REG_EDGE;
      default:       return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: CR/OR registers, 2-flop pin synchronizer, edge-to-ISR logic.
// Writes land on the next edge; IR visible 2 cycles after a pin change, ISR 3.
// No backpressure: every write strobe is accepted in the cycle it is presented.
// Interrupt registers/edge logic only exist with GPIO_BANK_IRQ_EN defined.
module gpio_port
  import gpio_bank_pkg::*;
#(
  parameter int PORT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PORT_W-1:0] wr_dat_i,
  input  logic              wr_cr_i,
  input  logic              wr_or_i,
  input  logic              wr_ier_i,
  input  logic              wr_isr_i,
  input  logic              wr_edge_i,
  input  logic [PORT_W-1:0] pins_i,
  output logic [PORT_W-1:0] cr_o,
  output logic [PORT_W-1:0] or_o,
  output logic [PORT_W-1:0] ir_o,
  output logic [PORT_W-1:0] ier_o,
  output logic [PORT_W-1:0] isr_o,
  output logic [PORT_W-1:0] edge_o,
  output logic              pend_o
);

  logic [PORT_W-1:0] cr_q, or_q, sync1_q, sync2_q;

  // Direction/output registers and the two synchronizer stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cr_q    <= '0;
      or_q    <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      if (wr_cr_i) cr_q <= wr_dat_i;
      if (wr_or_i) or_q <= wr_dat_i;
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
    end
  end

  assign cr_o = cr_q;
  assign or_o = or_q;
  assign ir_o = sync2_q;

`ifdef GPIO_BANK_IRQ_EN
  logic [PORT_W-1:0] ier_q, isr_q, isr_d, edge_q, prev_q, prev_d, evt;
  logic [1:0]        warm_q, warm_d;
  logic              warm;

  // Edge events, W1C merge (set beats clear), and warm-up bookkeeping.
  always_comb begin
    warm   = (warm_q != 2'd0);
    warm_d = warm ? (warm_q - 2'd1) : 2'd0;
    // While warming up, "previous" shadows the value sync2 is about to take,
    // so pins held high through reset never look like a fresh rising edge.
    prev_d = warm ? sync1_q : sync2_q;
    evt    = warm ? '0 : ((edge_q & sync2_q & ~prev_q) | (~edge_q & ~sync2_q & prev_q));
    isr_d  = (isr_q & ~(wr_isr_i ? wr_dat_i : '0)) | evt;
  end

  // Interrupt-side state: enables, status, polarity, previous flop, warm-up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ier_q  <= '0;
      isr_q  <= '0;
      edge_q <= '0;
      prev_q <= '0;
      warm_q <= 2'(GPIO_WARMUP);
    end else begin
      if (wr_ier_i)  ier_q  <= wr_dat_i;
      if (wr_edge_i) edge_q <= wr_dat_i;
      isr_q  <= isr_d;
      prev_q <= prev_d;
      warm_q <= warm_d;
    end
  end

  assign ier_o  = ier_q;
  assign isr_o  = isr_q;
  assign edge_o = edge_q;
  assign pend_o = |(isr_q & ier_q);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_ier_i, wr_isr_i, wr_edge_i};
  assign ier_o  = '0;
  assign isr_o  = '0;
  assign edge_o = '0;
  assign pend_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: NUM_PORTS gpio_port copies behind a 0x20-stride register map.
// Reads are combinational; writes take effect on the next edge; irq is registered.
// No backpressure: the bus is always ready. Interrupts need GPIO_BANK_IRQ_EN.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        we,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 wtData,
  output logic [31:0]                 rdData,
  output logic [NUM_PORTS*PORT_W-1:0] GPIO_CR,
  output logic [NUM_PORTS*PORT_W-1:0] GPIO_OR,
  input  logic [NUM_PORTS*PORT_W-1:0] GPIO_IR,
  output logic                        irq
);

  logic [2:0]  port_sel;
  gpio_reg_e   reg_sel;
  logic        wr_go;
  logic        unused_bus;

  logic [PORT_W-1:0] cr_a [NUM_PORTS];
  logic [PORT_W-1:0] or_a [NUM_PORTS];
  logic [PORT_W-1:0] ir_a [NUM_PORTS];
  logic [PORT_W-1:0] ier_a [NUM_PORTS];
  logic [PORT_W-1:0] isr_a [NUM_PORTS];
  logic [PORT_W-1:0] edge_a [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend_a;
  logic [PORT_W-1:0] rd_w;

  // Only addr[7:2] participate in decode; the rest alias.
  assign port_sel   = 3'(addr[7:0] >> GPIO_PORT_SHIFT);
  assign reg_sel    = gpio_decode({addr[4:2], 2'b00});
  assign wr_go      = ce && we;
  assign unused_bus = ^{addr[31:8], addr[1:0], wtData};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic hit;
    assign hit = wr_go && (port_sel == 3'(p));

    gpio_port #(.PORT_W(PORT_W)) u_port (
      .clk_i     (clk),
      .rst_i     (rst),
      .wr_dat_i  (wtData[PORT_W-1:0]),
      .wr_cr_i   (hit && (reg_sel == REG_CR)),
      .wr_or_i   (hit && (reg_sel == REG_OR)),
      .wr_ier_i  (hit && (reg_sel == REG_IER)),
      .wr_isr_i  (hit && (reg_sel == REG_ISR)),
      .wr_edge_i (hit && (reg_sel == REG_EDGE)),
      .pins_i    (GPIO_IR[p*PORT_W +: PORT_W]),
      .cr_o      (cr_a[p]),
      .or_o      (or_a[p]),
      .ir_o      (ir_a[p]),
      .ier_o     (ier_a[p]),
      .isr_o     (isr_a[p]),
      .edge_o    (edge_a[p]),
      .pend_o    (pend_a[p])
    );

    assign GPIO_CR[p*PORT_W +: PORT_W] = cr_a[p];
    assign GPIO_OR[p*PORT_W +: PORT_W] = or_a[p];
  end

  // Zero-latency read mux; out-of-range ports and unmapped offsets return 0.
  always_comb begin
    rd_w = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_sel == 3'(p)) begin
        case (reg_sel)
          REG_CR:   rd_w = cr_a[p];
          REG_OR:   rd_w = or_a[p];
          REG_IR:   rd_w = ir_a[p];
          REG_IER:  rd_w = ier_a[p];
          REG_ISR:  rd_w = isr_a[p];
          REG_EDGE: rd_w = edge_a[p];
          default:  rd_w = '0;
        endcase
      end
    end
    rdData = (ce && !we) ? 32'(rd_w) : 32'd0;
  end

`ifdef GPIO_BANK_IRQ_EN
  logic irq_q;

  // Interrupt is the registered OR of every port's pending (ISR & IER).
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |pend_a;
  end

  assign irq = irq_q;
`else
  logic unused_pend;
  assign unused_pend = |pend_a;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios plus randomized traffic
// compared against a pin-sample-history reference model.
// Works with or without GPIO_BANK_IRQ_EN defined.
module tb_gpio_bank;
  localparam int NP = 2;
  localparam int W  = 8;
  localparam int TW = NP * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0, we = 1'b0;
  logic [31:0]   addr = '0, wtData = '0, rdData;
  logic [TW-1:0] GPIO_CR, GPIO_OR;
  logic [TW-1:0] GPIO_IR = '0;
  logic          irq;

  gpio_bank #(.NUM_PORTS(NP), .PORT_W(W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wtData(wtData),
    .rdData(rdData), .GPIO_CR(GPIO_CR), .GPIO_OR(GPIO_OR), .GPIO_IR(GPIO_IR),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: registers as flat vectors plus the history of pin samples
  // taken since reset. A pin value sampled at edge k is readable after edge k+1
  // and is compared against its predecessor to raise ISR at edge k+2; the first
  // post-reset sample has no predecessor, so it never produces an event.
  logic [TW-1:0] m_cr = '0, m_or = '0, m_ier = '0, m_isr = '0, m_edge = '0;
  logic          m_irq = 1'b0;
  logic [TW-1:0] samp[$];

  function automatic logic [TW-1:0] m_ir();
    if (samp.size() >= 2) return samp[samp.size()-2];
    return '0;
  endfunction

  function automatic logic [31:0] m_read(input logic c, input logic w, input logic [31:0] a);
    int p;
    logic [TW-1:0] ir;
    p  = int'(a[7:5]);
    ir = m_ir();
    if (!c || w || p >= NP) return 32'd0;
    case (a[4:2])
      3'd0: return 32'(m_cr[p*W +: W]);
      3'd1: return 32'(m_or[p*W +: W]);
      3'd2: return 32'(ir[p*W +: W]);
`ifdef GPIO_BANK_IRQ_EN
      3'd3: return 32'(m_ier[p*W +: W]);
      3'd4: return 32'(m_isr[p*W +: W]);
      3'd5: return 32'(m_edge[p*W +: W]);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_clock();
    logic [TW-1:0] set, clr, older, newer;
    logic nirq;
    int p, n;
    if (rst) begin
      m_cr = '0; m_or = '0; m_ier = '0; m_isr = '0; m_edge = '0; m_irq = 1'b0;
      samp.delete();
      return;
    end
    nirq = |(m_isr & m_ier);
    samp.push_back(GPIO_IR);
    if (samp.size() > 4) void'(samp.pop_front());
    n = samp.size();
    set = '0;
    if (n >= 4) begin
      older = samp[n-4];
      newer = samp[n-3];
      set = (m_edge & newer & ~older) | (~m_edge & ~newer & older);
    end
    clr = '0;
    p = int'(addr[7:5]);
    if (ce && we && p < NP) begin
      case (addr[4:2])
        3'd0: m_cr[p*W +: W] = wtData[W-1:0];
        3'd1: m_or[p*W +: W] = wtData[W-1:0];
`ifdef GPIO_BANK_IRQ_EN
        3'd3: m_ier[p*W +: W]  = wtData[W-1:0];
        3'd4: clr[p*W +: W]    = wtData[W-1:0];
        3'd5: m_edge[p*W +: W] = wtData[W-1:0];
`endif
        default: ;
      endcase
    end
`ifdef GPIO_BANK_IRQ_EN
    m_isr = (m_isr & ~clr) | set;
    m_irq = nirq;
`else
    m_irq = 1'b0;
`endif
  endtask

  // One bus cycle: drive at negedge, check the combinational read, clock,
  // then check the registered outputs against the model.
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [TW-1:0] pins);
    @(negedge clk);
    rst = r; ce = c; we = w; addr = a; wtData = d; GPIO_IR = pins;
    #1;
    last_rd = rdData;
    check("rdData", rdData, m_read(c, w, a));
    @(posedge clk);
    m_clock();
    #1;
    check("GPIO_CR", 32'(GPIO_CR), 32'(m_cr));
    check("GPIO_OR", 32'(GPIO_OR), 32'(m_or));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [TW-1:0] pins);
    step(1'b0, 1'b1, 1'b1, a, d, pins);
  endtask

  task automatic rd(input logic [31:0] a, input logic [TW-1:0] pins);
    step(1'b0, 1'b1, 1'b0, a, 32'd0, pins);
  endtask

  task automatic idle(input logic [TW-1:0] pins);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, pins);
  endtask

  initial begin
    logic [TW-1:0] pins;
    logic [31:0]   a;
    pins = '0;

    // Reset with a write presented alongside it: the write must be dropped.
    repeat (3) step(1'b1, 1'b1, 1'b1, 32'h20, 32'hFF, pins);
    check("rst_cr", 32'(GPIO_CR), 32'h0);
    check("rst_or", 32'(GPIO_OR), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Port 1 CR/OR writes, port 0 untouched.
    wr(32'h20, 32'hFF, pins);
    wr(32'h24, 32'hA5, pins);
    check("p1_cr", 32'(GPIO_CR[15:8]), 32'hFF);
    check("p1_or", 32'(GPIO_OR[15:8]), 32'hA5);
    check("p0_cr", 32'(GPIO_CR[7:0]), 32'h00);
    check("p0_or", 32'(GPIO_OR[7:0]), 32'h00);
    rd(32'h24, pins);
    check("p1_or_rd", last_rd, 32'hA5);

    // Out-of-range port, ce=0, and an ignored write to IR.
    rd(32'h40, pins);
    check("oor_rd", last_rd, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h24, 32'h0, pins);
    check("ce0_rd", last_rd, 32'h0);
    wr(32'h08, 32'hFF, pins);
    rd(32'h08, pins);
    check("ir_wr_ignored", last_rd, 32'h0);

`ifdef GPIO_BANK_IRQ_EN
    // Rising edge on bit 0: IR after 2 edges, ISR after 3, irq after 4.
    wr(32'h14, 32'h01, pins);
    wr(32'h0C, 32'h01, pins);
    pins = 16'h0001;
    idle(pins);
    rd(32'h08, pins);
    check("ir_1cyc", last_rd, 32'h0);
    rd(32'h08, pins);
    check("ir_2cyc", last_rd, 32'h1);
    check("irq_not_yet", 32'(irq), 32'h0);
    rd(32'h10, pins);
    check("isr_set", last_rd, 32'h1);
    check("irq_set", 32'(irq), 32'h1);

    // Clear, let the pin fall (no event with EDGE=1), then collide set with W1C.
    pins = '0;
    wr(32'h10, 32'h01, pins);
    repeat (5) idle(pins);
    rd(32'h10, pins);
    check("isr_clr0", last_rd, 32'h0);
    pins = 16'h0001;
    idle(pins);
    idle(pins);
    wr(32'h10, 32'h01, pins);
    rd(32'h10, pins);
    check("isr_set_wins", last_rd, 32'h1);
    wr(32'h10, 32'h00, pins);
    rd(32'h10, pins);
    check("isr_w0_keeps", last_rd, 32'h1);
    wr(32'h10, 32'h01, pins);
    check("irq_hold", 32'(irq), 32'h1);
    rd(32'h10, pins);
    check("isr_clr", last_rd, 32'h0);
    check("irq_drop", 32'(irq), 32'h0);

    // Pins held high through reset must not look like rising edges.
    pins = '1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, pins);
    wr(32'h14, 32'hFF, pins);
    wr(32'h34, 32'hFF, pins);
    repeat (6) idle(pins);
    rd(32'h10, pins);
    check("warm_isr_p0", last_rd, 32'h0);
    rd(32'h30, pins);
    check("warm_isr_p1", last_rd, 32'h0);
`else
    // No interrupt logic: registers read 0, writes ignored, irq stays low.
    wr(32'h0C, 32'hFF, pins);
    wr(32'h14, 32'hFF, pins);
    for (int i = 0; i < 8; i++) begin
      pins = ~pins;
      idle(pins);
      check("noirq_irq", 32'(irq), 32'h0);
    end
    rd(32'h0C, pins);
    check("noirq_ier", last_rd, 32'h0);
    rd(32'h10, pins);
    check("noirq_isr", last_rd, 32'h0);
    rd(32'h14, pins);
    check("noirq_edge", last_rd, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[7:5] = 3'($urandom_range(0, NP - 1));
      if ($urandom_range(0, 2) == 0) pins = TW'($urandom);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), a, $urandom, pins);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter NUM_PORTS, default 2, is the number of independent GPIO ports (1..8).
REQ-002 Parameter PORT_W, default 8, is the bits per port (1..32).
REQ-003 clk  input  1  is the single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 ce  input  1  is the bus chip enable from the memory/IO controller.
REQ-006 we  input  1  selects the access type: 1 = write, 0 = read; it is valid only when ce=1.
REQ-007 addr  input  32  is the byte address; the block decodes only bits [7:2].
REQ-008 wtData  input  32  is the write data; the block uses bits [PORT_W-1:0].
REQ-009 rdData  output  32  is the read data, zero-extended from PORT_W bits.
REQ-010 GPIO_CR  output  NUM_PORTS*PORT_W  carries the per-bit direction (1 = output); port p occupies slice p.
REQ-011 GPIO_OR  output  NUM_PORTS*PORT_W  carries the output register values.
REQ-012 GPIO_IR  input  NUM_PORTS*PORT_W  carries the asynchronous pin inputs.
REQ-013 irq  output  1  is the level interrupt: the OR over all ports of (ISR & IER).

Function
REQ-014 Each port p SHALL have a register window at base p*0x20, with these word offsets:
- 0x00 CR (read/write)
- 0x04 OR (read/write)
- 0x08 IR (read-only)
- 0x0C IER (read/write)
- 0x10 ISR (read; write-1-to-clear)
- 0x14 EDGE (read/write; 1 = rising, 0 = falling)
REQ-015 Writes SHALL take effect at the clock edge where ce=1 and we=1; a write to IR, to an unmapped offset, or to port index >= NUM_PORTS SHALL be ignored.
REQ-016 Reads SHALL be combinational (zero latency) while ce=1 and we=0.
- rdData SHALL be 0 when ce=0, during a write, or for an unmapped/out-of-range address.
REQ-017 Each GPIO_IR bit SHALL pass through a 2-flop synchronizer; IR reads return the second-stage value, so an input change is visible 2 cycles later.
REQ-018 Edge detection SHALL compare the second stage against a third "previous" flop:
- with EDGE=1, a 0->1 transition sets that ISR bit;
- with EDGE=0, a 1->0 transition sets that ISR bit.
REQ-019 ISR bits SHALL be set regardless of IER; IER gates only irq.
REQ-020 When an edge event and a W1C write hit the same ISR bit in the same cycle, the set SHALL win (the bit stays 1).
REQ-021 Writing 0 to an ISR bit SHALL leave it unchanged.
REQ-022 A 2-cycle warm-up counter SHALL start at reset and suppress ISR setting until the synchronizer has refilled; pins held high through reset SHALL NOT raise a rising-edge event.
REQ-023 GPIO_OR and GPIO_CR SHALL be driven directly from the OR and CR registers with no combinational path from the bus.
REQ-024 irq SHALL be registered, asserting 1 cycle after the ISR&IER condition becomes true.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL clear CR, OR, IER, ISR, EDGE, all synchronizer/previous flops and irq, and load the warm-up counter with 2.
REQ-026 An access presented in the same cycle as rst=1 SHALL be discarded.

Configuration
REQ-027 Macro GPIO_BANK_IRQ_EN defined: the IER, ISR and EDGE registers, the previous flops, the warm-up counter and irq SHALL be implemented as specified above.
REQ-028 Macro GPIO_BANK_IRQ_EN undefined: those registers SHALL be absent, their offsets SHALL read 0 and ignore writes, and irq SHALL be tied to 0.

Structure
REQ-029 The register offsets (GPIO_OFF_CR ... GPIO_OFF_EDGE), the port stride 0x20 and the warm-up length SHALL be defined in the shared SOC header.
REQ-030 One sub-module, gpio_port, SHALL hold one port's registers, synchronizer and edge logic; gpio_bank SHALL instantiate NUM_PORTS copies and handle address decode, the read mux and the irq OR.

Verification
REQ-031 Write CR=0xFF, OR=0xA5 to port 1 (addr 0x20, 0x24) -> GPIO_CR[15:8]=0xFF and GPIO_OR[15:8]=0xA5 the next cycle; port 0 unchanged.
REQ-032 Set GPIO_IR[0] 0->1 -> IR read at 0x08 returns 0x01 exactly 2 cycles later; with EDGE=1 and IER=1, ISR=0x01 and irq=1 one cycle after that.
REQ-033 Write ISR=0x01 in the same cycle as a new rising edge on bit 0 -> ISR stays 0x01; a clear with no edge -> ISR=0 and irq drops the next cycle.
REQ-034 Hold GPIO_IR=0xFF through reset and release it -> ISR stays 0 for all ports.
REQ-035 Read addr 0x40 with NUM_PORTS=2, and read any address with ce=0 -> rdData=0; a write to 0x08 leaves IR unchanged.
REQ-036 Build without GPIO_BANK_IRQ_EN, toggle the pins -> irq=0, and reads of 0x0C, 0x10 and 0x14 return 0.
